// File: rtl/uart_rx_controller.sv
// uart_rx_controller: buffers words from a UART receiver into a small FIFO
// and presents them on a valid/ready stream, with flush, overflow and count.
//
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   enable_i              accept receiver words while high
//   clear_i               flush request (enter FLUSH)
//   rx_done_i, rx_data_i  word-complete pulse and word from the receiver
//   m_valid_o, m_data_o   buffer head available / head word
//   m_ready_i             consumer accepts the head
//   level_o               buffer occupancy
//   overflow_o            sticky flag, set when a word is dropped
//   rx_count_o            saturating count of accepted words
//   state_o               controller state (OFF/RUN/FLUSH)
module uart_rx_controller #(
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       enable_i,
    input  logic                       clear_i,
    input  logic                       rx_done_i,
    input  logic [WORD_BITS-1:0]       rx_data_i,
    output logic                       m_valid_o,
    output logic [WORD_BITS-1:0]       m_data_o,
    input  logic                       m_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       overflow_o,
    output logic [CNT_BITS-1:0]        rx_count_o,
    output logic [1:0]                 state_o
);

    localparam int unsigned PTR_BITS = $clog2(DEPTH);
    localparam int unsigned LVL_BITS = PTR_BITS + 1;

    typedef enum logic [1:0] {
        OFF   = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t                state;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [WORD_BITS-1:0]  mem [DEPTH];

    logic push_req;
    logic pop;
    logic full;
    logic do_push;
    logic drop;

    // Head and status are taken straight from registers; no path from m_ready_i.
    assign m_valid_o = (level_o != '0);
    assign m_data_o  = mem[rd_ptr];
    assign state_o   = state;

    // Handshake qualification; a full buffer still accepts when it pops the same cycle.
    always_comb begin
        push_req = 1'b0;
        pop      = 1'b0;
        full     = 1'b0;
        do_push  = 1'b0;
        drop     = 1'b0;
        push_req = (state == RUN) && rx_done_i;
        pop      = m_valid_o && m_ready_i && (state != FLUSH);
        full     = (level_o == LVL_BITS'(DEPTH));
        do_push  = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    // Controller state, buffer storage, pointers, occupancy and status flags.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= OFF;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_o    <= '0;
            overflow_o <= 1'b0;
            rx_count_o <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            // clear_i wins over enable_i; the unused encoding falls back to OFF.
            case (state)
                OFF, RUN, FLUSH: begin
                    if (clear_i) begin
                        state <= FLUSH;
                    end else if (enable_i) begin
                        state <= RUN;
                    end else begin
                        state <= OFF;
                    end
                end
                default: state <= clear_i ? FLUSH : OFF;
            endcase

            if (state == FLUSH) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                level_o    <= '0;
                overflow_o <= 1'b0;
                rx_count_o <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= rx_data_i;
                    wr_ptr      <= wr_ptr + PTR_BITS'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_BITS'(1);
                end
                if (do_push && !pop) begin
                    level_o <= level_o + LVL_BITS'(1);
                end else if (pop && !do_push) begin
                    level_o <= level_o - LVL_BITS'(1);
                end
                if (drop) begin
                    overflow_o <= 1'b1;
                end
                if (do_push && (rx_count_o != '1)) begin
                    rx_count_o <= rx_count_o + CNT_BITS'(1);
                end
            end
        end
    end

endmodule
